// File: rtl/ethernet_encapsulation.sv
// GMII transmit framer: pulls a queued payload from the TX FIFO and emits
// preamble, SFD, MAC header, length, payload, zero pad and FCS, then holds the inter-frame gap.
module ethernet_encapsulation #(
    parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
    parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
    parameter int          MIN_PAYLOAD          = 46,
    parameter int          MAX_PAYLOAD          = 1500,
    parameter int          IFG_CYCLES           = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pct_qued,
    input  logic [10:0] payload_len,
    output logic        bf_in_r_en,
    input  logic [7:0]  ff_out_data_in,
    output logic        bf_in_pct_txed,
    output logic        len_err,
    output logic        busy,
    output logic [7:0]  gmii_data_out,
    output logic        gmii_dv,
    output logic        gmii_er
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] LP_MIN      = 11'(MIN_PAYLOAD);
    localparam logic [10:0] LP_MAX      = 11'(MAX_PAYLOAD);
    localparam logic [10:0] LP_PAD_BASE = 11'(MIN_PAYLOAD - 1);
    // Outputs are registered one cycle behind the state, so the IDLE cycle
    // itself supplies the last idle bus cycle of the gap.
    localparam logic [10:0] LP_IFG_LAST = 11'(IFG_CYCLES - 2);

    state_t      r_state, w_next;
    logic [10:0] r_cnt, r_len, w_last;
    logic [31:0] r_crc, w_fcs;
    logic [7:0]  r_data, w_byte;
    logic [2:0]  w_mac_idx;
    logic        r_dv, r_txed, r_len_err;
    logic        w_dv, w_crc_en, w_accept, w_reject, w_txed, w_rd, w_done;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign w_mac_idx = 3'd5 - r_cnt[2:0];
    assign w_fcs     = ~r_crc;
    assign w_done    = (r_cnt == w_last);

    always_comb begin
        w_next   = r_state;
        w_byte   = 8'h00;
        w_dv     = 1'b0;
        w_crc_en = 1'b0;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_txed   = 1'b0;
        w_rd     = 1'b0;
        w_last   = 11'd0;
        case (r_state)
            S_IDLE: begin
                // The cycle after a rejection is skipped so a held request re-samples every other cycle.
                if (pct_qued && !r_len_err) begin
                    if (payload_len != 11'd0 && payload_len <= LP_MAX) begin
                        w_accept = 1'b1;
                        w_next   = S_PRE;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_PRE: begin
                w_dv   = 1'b1;
                w_byte = 8'h55;
                w_last = 11'd6;
                if (w_done) w_next = S_SFD;
            end
            S_SFD: begin
                w_dv   = 1'b1;
                w_byte = 8'hD5;
                w_next = S_DST;
            end
            S_DST: begin
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = destination_mac_addr[{w_mac_idx, 3'b000} +: 8];
                w_last   = 11'd5;
                if (w_done) w_next = S_SRC;
            end
            S_SRC: begin
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = source_mac_addr[{w_mac_idx, 3'b000} +: 8];
                w_last   = 11'd5;
                if (w_done) w_next = S_LEN;
            end
            S_LEN: begin
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = (r_cnt == 11'd0) ? {5'b0, r_len[10:8]} : r_len[7:0];
                w_last   = 11'd1;
                w_rd     = (r_cnt == 11'd1);
                if (w_done) w_next = S_PAY;
            end
            S_PAY: begin
                // Reads run one byte ahead of the bus to cover the FIFO's read latency.
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = ff_out_data_in;
                w_last   = r_len - 11'd1;
                w_rd     = (r_cnt + 11'd1 < r_len);
                if (w_done) w_next = (r_len < LP_MIN) ? S_PAD : S_FCS;
            end
            S_PAD: begin
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_last   = LP_PAD_BASE - r_len;
                if (w_done) w_next = S_FCS;
            end
            S_FCS: begin
                w_dv   = 1'b1;
                w_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                w_last = 11'd3;
                w_txed = w_done;
                if (w_done) w_next = S_IFG;
            end
            S_IFG: begin
                w_last = LP_IFG_LAST;
                if (w_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 11'd0;
            r_len     <= 11'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_data    <= 8'h00;
            r_dv      <= 1'b0;
            r_txed    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == S_IDLE || w_next != r_state) ? 11'd0 : r_cnt + 11'd1;
            r_data    <= w_byte;
            r_dv      <= w_dv;
            r_txed    <= w_txed;
            r_len_err <= w_reject;
            if (w_accept) begin
                r_len <= payload_len;
                r_crc <= 32'hFFFFFFFF;
            end else if (w_crc_en) begin
                r_crc <= crcByte(r_crc, w_byte);
            end
        end
    end

    assign bf_in_r_en     = w_rd;
    assign busy           = (r_state != S_IDLE);
    assign gmii_data_out  = r_data;
    assign gmii_dv        = r_dv;
    assign gmii_er        = 1'b0;
    assign bf_in_pct_txed = r_txed;
    assign len_err        = r_len_err;

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// Self-checking bench for ethernet_encapsulation: random payloads are framed by a
// queue-based reference model and compared byte for byte, with timing of reads, pulses and gaps.
module tb_ethernet_encapsulation;

    typedef logic [7:0] byteQ_t[$];

    localparam logic [47:0] DST_MAC = 48'h023528fbdd66;
    localparam logic [47:0] SRC_MAC = 48'h072227acdb65;
    localparam int          MINP    = 46;
    localparam int          IFG     = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pct_qued = 1'b0;
    logic [10:0] payload_len = 11'd0;
    logic        bf_in_r_en;
    logic [7:0]  ff_out_data_in;
    logic        bf_in_pct_txed, len_err, busy;
    logic [7:0]  gmii_data_out;
    logic        gmii_dv, gmii_er;

    ethernet_encapsulation dut (
        .clk(clk), .rst(rst), .pct_qued(pct_qued), .payload_len(payload_len),
        .bf_in_r_en(bf_in_r_en), .ff_out_data_in(ff_out_data_in),
        .bf_in_pct_txed(bf_in_pct_txed), .len_err(len_err), .busy(busy),
        .gmii_data_out(gmii_data_out), .gmii_dv(gmii_dv), .gmii_er(gmii_er)
    );

    always #5 clk = ~clk;

    int     nChecks = 0, nFails = 0;
    int     cyc = 0, rdPtr = 0;
    int     idleBad = 0, erSeen = 0, dvNoBusy = 0, busyCycles = 0;
    int     snapIdle, snapEr, snapDvNoBusy, snapBusy, acceptCyc;
    byteQ_t fifoQ, busQ, payQ;
    int     busCyc[$], rdCyc[$], txedCyc[$], errCyc[$];

    // Upstream FIFO read side: one-cycle read latency.
    always @(posedge clk) begin
        if (bf_in_r_en) begin
            ff_out_data_in <= fifoQ[rdPtr];
            rdPtr          <= rdPtr + 1;
        end
    end

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (gmii_dv) begin
            busQ.push_back(gmii_data_out);
            busCyc.push_back(cyc);
        end
        if (!gmii_dv && gmii_data_out != 8'h00) idleBad++;
        if (gmii_er) erSeen++;
        if (gmii_dv && !busy) dvNoBusy++;
        if (busy) busyCycles++;
        if (bf_in_r_en) rdCyc.push_back(cyc);
        if (bf_in_pct_txed) txedCyc.push_back(cyc);
        if (len_err) errCyc.push_back(cyc);
    end

    function automatic logic [31:0] refFcs(input byteQ_t q, input int from);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return ~c;
    endfunction

    function automatic byteQ_t buildFrame(input byteQ_t pay);
        byteQ_t      f;
        logic [47:0] d, s;
        logic [31:0] fcs;
        int          n;
        d = DST_MAC;
        s = SRC_MAC;
        n = pay.size();
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) f.push_back(d[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(s[8*i +: 8]);
        f.push_back(8'(n >> 8));
        f.push_back(8'(n & 255));
        for (int i = 0; i < n; i++) f.push_back(pay[i]);
        for (int i = n; i < MINP; i++) f.push_back(8'h00);
        fcs = refFcs(f, 8);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, required %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clearLogs();
        busQ.delete();
        busCyc.delete();
        rdCyc.delete();
        txedCyc.delete();
        errCyc.delete();
        snapIdle     = idleBad;
        snapEr       = erSeen;
        snapDvNoBusy = dvNoBusy;
        snapBusy     = busyCycles;
    endtask

    task automatic fillRandom(input int len);
        payQ.delete();
        for (int i = 0; i < len; i++) payQ.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic applyStimulus(input string tag, input int len, input bit hold);
        for (int i = 0; i < payQ.size(); i++) fifoQ.push_back(payQ[i]);
        payload_len = 11'(len);
        pct_qued    = 1'b1;
        for (int k = 0; k < 20 && !busy; k++) tick();
        acceptCyc = cyc;
        checkOutput({tag, ".accepted"}, busy, 1);
        if (!hold) begin
            pct_qued    = 1'b0;
            payload_len = 11'($urandom_range(0, 2047));
        end
    endtask

    task automatic waitTxed(input string tag, input int n);
        for (int k = 0; k < 4000 && txedCyc.size() < n; k++) tick();
        checkOutput({tag, ".txedCount"}, txedCyc.size(), n);
        for (int k = 0; k < 40 && busy; k++) tick();
        checkOutput({tag, ".busyDrop"}, busy, 0);
        tick();
    endtask

    task automatic checkFrame(input string tag, input byteQ_t pay, input int dvBase,
                              input int rdBase, input int txIdx, input int acceptAt);
        byteQ_t exp;
        int     n, len;
        exp = buildFrame(pay);
        n   = exp.size();
        len = pay.size();
        checkOutput({tag, ".dvAvail"}, int'(busQ.size() >= dvBase + n), 1);
        checkOutput({tag, ".rdAvail"}, int'(rdCyc.size() >= rdBase + len), 1);
        checkOutput({tag, ".txAvail"}, int'(txedCyc.size() > txIdx), 1);
        if (busQ.size() < dvBase + n || rdCyc.size() < rdBase + len || txedCyc.size() <= txIdx)
            return;
        checkOutput({tag, ".firstPre"}, busCyc[dvBase], acceptAt + 1);
        checkOutput({tag, ".dvContig"}, busCyc[dvBase + n - 1] - busCyc[dvBase], n - 1);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.byte%0d", tag, i), busQ[dvBase + i], exp[i]);
        checkOutput({tag, ".firstRd"}, rdCyc[rdBase], busCyc[dvBase + 22] - 2);
        checkOutput({tag, ".rdContig"}, rdCyc[rdBase + len - 1] - rdCyc[rdBase], len - 1);
        checkOutput({tag, ".txedAt"}, txedCyc[txIdx], busCyc[dvBase + n - 1]);
    endtask

    task automatic runSingle(input string tag, input int len);
        int dvLen;
        dvLen = 26 + ((len > MINP) ? len : MINP);
        clearLogs();
        applyStimulus(tag, len, 1'b0);
        waitTxed(tag, 1);
        checkOutput({tag, ".dvTotal"}, busQ.size(), dvLen);
        checkOutput({tag, ".rdTotal"}, rdCyc.size(), len);
        checkFrame(tag, payQ, 0, 0, 0, acceptCyc);
        checkOutput({tag, ".idleData"}, idleBad - snapIdle, 0);
        checkOutput({tag, ".dvOutsideBusy"}, dvNoBusy - snapDvNoBusy, 0);
    endtask

    initial begin
        byteQ_t payA, payB;
        int     acceptA, acceptB;

        rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset.dv", gmii_dv, 0);
        checkOutput("reset.data", gmii_data_out, 0);
        checkOutput("reset.rdEn", bf_in_r_en, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.lenErr", len_err, 0);
        checkOutput("reset.txed", bf_in_pct_txed, 0);
        rst = 1'b1;
        repeat (2) tick();

        payQ.delete();
        for (int i = 0; i < 46; i++) payQ.push_back(8'(i));
        runSingle("ramp46", 46);

        fillRandom(1);
        runSingle("len1", 1);

        fillRandom(1500);
        runSingle("len1500", 1500);

        clearLogs();
        payload_len = 11'd1501;
        pct_qued    = 1'b1;
        tick();
        checkOutput("len1501.pulse", len_err, 1);
        tick();
        tick();
        pct_qued = 1'b0;
        repeat (4) tick();
        checkOutput("len1501.pulseCount", errCyc.size(), 2);
        if (errCyc.size() == 2) checkOutput("len1501.resample", errCyc[1] - errCyc[0], 2);
        checkOutput("len1501.dv", busQ.size(), 0);
        checkOutput("len1501.rd", rdCyc.size(), 0);
        checkOutput("len1501.busy", busyCycles - snapBusy, 0);

        clearLogs();
        payload_len = 11'd0;
        pct_qued    = 1'b1;
        tick();
        checkOutput("len0.pulse", len_err, 1);
        pct_qued = 1'b0;
        repeat (4) tick();
        checkOutput("len0.pulseCount", errCyc.size(), 1);
        checkOutput("len0.dv", busQ.size(), 0);
        checkOutput("len0.rd", rdCyc.size(), 0);
        checkOutput("len0.busy", busyCycles - snapBusy, 0);

        fillRandom($urandom_range(2, 45));
        runSingle("randShort", payQ.size());
        fillRandom($urandom_range(47, 200));
        runSingle("randLong", payQ.size());

        clearLogs();
        fillRandom(60);
        payA = payQ;
        fillRandom(60);
        payB = payQ;
        for (int i = 0; i < 60; i++) fifoQ.push_back(payA[i]);
        payQ.delete();
        payload_len = 11'd60;
        applyStimulus("b2bA", 60, 1'b1);
        acceptA = acceptCyc;
        for (int k = 0; k < 400 && txedCyc.size() < 1; k++) tick();
        for (int k = 0; k < 40 && busy; k++) tick();
        for (int k = 0; k < 40 && !busy; k++) tick();
        acceptB = cyc;
        checkOutput("b2bB.accepted", busy, 1);
        pct_qued = 1'b0;
        for (int i = 0; i < 60; i++) fifoQ.push_back(payB[i]);
        waitTxed("b2b", 2);
        checkOutput("b2b.dvTotal", busQ.size(), 172);
        checkOutput("b2b.rdTotal", rdCyc.size(), 120);
        checkFrame("b2bA", payA, 0, 0, 0, acceptA);
        checkFrame("b2bB", payB, 86, 60, 1, acceptB);
        if (busCyc.size() >= 87) checkOutput("b2b.gap", busCyc[86] - busCyc[85] - 1, IFG);

        clearLogs();
        fillRandom(80);
        applyStimulus("abort", 80, 1'b0);
        for (int k = 0; k < 200 && busQ.size() < 33; k++) tick();
        checkOutput("abort.reachedByte10", busQ.size(), 33);
        rst = 1'b0;
        #1;
        checkOutput("abort.dv", gmii_dv, 0);
        checkOutput("abort.data", gmii_data_out, 0);
        checkOutput("abort.rdEn", bf_in_r_en, 0);
        checkOutput("abort.busy", busy, 0);
        repeat (3) tick();
        checkOutput("abort.noTxed", txedCyc.size(), 0);
        while (fifoQ.size() > rdPtr) void'(fifoQ.pop_back());
        rst = 1'b1;
        tick();
        fillRandom(46);
        runSingle("afterAbort", 46);

        checkOutput("gmiiEr.neverHigh", erSeen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ethernet_encapsulation.md
Name: ethernet_encapsulation

Overview:
GMII transmit framer that sits directly upstream of ethernet_decapsulation and drives the GMII TX bus. When a payload is queued in the TX async FIFO, it emits one complete 802.3 frame: preamble, SFD, destination MAC, source MAC, length, payload, zero pad and FCS. It then enforces the inter-frame gap. Payload bytes are pulled from the FIFO read side via bf_in_r_en / ff_out_data_in.

Parameters:
destination_mac_addr, 48'h023528fbdd66, DST field; sent MSB byte first.
source_mac_addr, 48'h072227acdb65, SRC field; sent MSB byte first.
MIN_PAYLOAD, 46, payloads shorter than this are zero-padded up to it.
MAX_PAYLOAD, 1500, largest accepted payload_len.
IFG_CYCLES, 12, idle cycles forced after each frame's last FCS byte.

Ports:
clk  input  1  GMII TX clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
pct_qued  input  1  level: a complete payload is in the FIFO.
payload_len  input  11  payload byte count; sampled with pct_qued.
bf_in_r_en  output  1  FIFO read strobe; data valid on ff_out_data_in the next cycle.
ff_out_data_in  input  8  FIFO read data.
bf_in_pct_txed  output  1  one-cycle pulse: frame finished, upstream decrements packet count.
len_err  output  1  one-cycle pulse: payload_len rejected.
busy  output  1  high from frame accept through the end of IFG.
gmii_data_out  output  8  GMII TXD (registered).
gmii_dv  output  1  GMII TX_EN (registered).
gmii_er  output  1  GMII TX_ER (registered); always 0.

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, CRC = 32'hFFFFFFFF, all counters 0. Deassertion takes effect on the next clk edge.
- States: IDLE -> PRE -> SFD -> DST -> SRC -> LEN -> PAY -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - pct_qued=1 and 1 <= payload_len <= MAX_PAYLOAD: latch len, go to PRE.
  - payload_len=0 or > MAX_PAYLOAD: pulse len_err for 1 cycle, issue no reads and no dv, stay IDLE for 1 cycle, then re-sample.
- Field sizes and contents:
  - PRE: 7 bytes of 8'h55.
  - SFD: 1 byte 8'hD5.
  - DST: 6 bytes. SRC: 6 bytes.
  - LEN: 2 bytes, latched len, high byte first.
  - PAY: len bytes from FIFO, in order.
  - PAD: max(0, MIN_PAYLOAD - len) bytes of 8'h00; state skipped if count is 0.
  - FCS: 4 bytes.
- gmii_dv is high for every byte from the first PRE byte through the last FCS byte, with no gaps. gmii_dv is low in IDLE and IFG, and gmii_data_out = 0 there.
- Frame length: total dv cycles = 8 + 14 + max(len, 46) + 4.
- Latency: first PRE byte appears on gmii_data_out 1 cycle after the accept edge.
- FIFO reads:
  - Exactly len strobes per frame, issued on consecutive cycles.
  - First strobe is asserted 2 cycles before payload byte 0 appears on gmii_data_out.
  - No strobe outside this window.
- CRC-32, IEEE 802.3:
  - Reflected polynomial 0xEDB88320, byte-wise LSB-first update.
  - Init 32'hFFFFFFFF, cleared at accept.
  - Covers DST through PAD; excludes preamble/SFD.
  - FCS is the bitwise inverse of the final CRC, sent least-significant byte first.
- bf_in_pct_txed: high during the cycle the last FCS byte is on the bus.
- IFG: exactly IFG_CYCLES cycles with dv=0. pct_qued is ignored during IFG. A pct_qued held high is accepted on the first IDLE cycle, giving exactly IFG_CYCLES idle bus cycles between frames.
- payload_len changing mid-frame has no effect; only the latched value is used.
- Counters must not wrap: byte counter is 11 bits and saturates at the state-exit compare.
- Reset asserted mid-frame: outputs go to 0 immediately (async), with no FCS and no bf_in_pct_txed. Upstream is responsible for flushing the FIFO.
- busy: high from the cycle after accept until the cycle IFG ends; low in IDLE.

Test Plan:
- len=46, FIFO bytes 0x00..0x2D -> 72 consecutive dv cycles.
  - Bytes 0-7: 55x7, D5. DST: 02 35 28 fb dd 66. SRC: 07 22 27 ac db 65. LEN: 00 2E.
  - Payload appears in order; FCS matches the software CRC32 model.
  - bf_in_pct_txed pulses on dv cycle 72; then 12 idle cycles.
- len=1 -> LEN=00 01, 1 payload byte, 45 zero pad bytes, 72 dv cycles, exactly 1 FIFO read.
- len=1500 -> 1526 dv cycles, 1500 consecutive r_en cycles, first r_en 2 cycles before payload byte 0; FCS correct.
- len=1501, then len=0 -> len_err pulses each time, gmii_dv stays 0, bf_in_r_en stays 0, busy stays 0.
- Back-to-back: pct_qued held high with two 60-byte payloads -> second PRE byte starts after exactly 12 dv=0 cycles following the first frame's last FCS byte.
- rst low at payload byte 10 -> gmii_dv, gmii_data_out and bf_in_r_en are 0 within the same cycle. After release with pct_qued=1, len=46, a clean frame with correct FCS follows.
